// File: rtl/spimbox_seq.sv
// spimbox_seq: host-side sequencer in front of the SPI mailbox.
//
// Accepts one 64-bit request word over a valid/ready handshake and writes it into
// the mailbox as eight byte-strobed writes, most significant byte first. It then
// waits for the mailbox receive-valid edge that marks the end of the SPI exchange,
// reads the eight received bytes back and returns them as one 64-bit response
// word. If the exchange does not finish within TIMEOUT wait cycles, it returns a
// zero word flagged by rsp_timeout_o.
//
// Ports:
//   clk_i, rst_ni       clock (shared with the mailbox), async active-low reset
//   req_valid_i/ready_o request handshake; req_data_i[63:56] is sent first
//   rsp_valid_o/ready_i response handshake; rsp_data_o[63:56] is received first
//   rsp_timeout_o       response is a timeout (rsp_data_o is zero)
//   mb_windex_o         mailbox write byte index
//   mb_wdata_o          mailbox write byte
//   mb_wstrb_o          mailbox write strobe (mailbox commits on its falling edge)
//   mb_rindex_o         mailbox read byte index
//   mb_rdata_i          mailbox read byte, one cycle after mb_rindex_o
//   mb_valid_i          mailbox receive-data valid (low during a transfer)

module spimbox_seq #(
    parameter int unsigned TIMEOUT = 4096  // 1..65535
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic [63:0] req_data_i,
    output logic        rsp_valid_o,
    input  logic        rsp_ready_i,
    output logic [63:0] rsp_data_o,
    output logic        rsp_timeout_o,
    output logic [2:0]  mb_windex_o,
    output logic [7:0]  mb_wdata_o,
    output logic        mb_wstrb_o,
    output logic [2:0]  mb_rindex_o,
    input  logic [7:0]  mb_rdata_i,
    input  logic        mb_valid_i
);

    typedef enum logic [2:0] {
        StIdle,
        StWrite,
        StWait,
        StRead,
        StResp
    } state_e;

    localparam logic [15:0] TmoLast = 16'(TIMEOUT - 1);

    state_e      state_q;
    logic [63:0] req_q;
    logic [3:0]  wr_cnt_q;   // WRITE cycle 0..15: byte = cnt[3:1], strobe when cnt[0] == 0
    logic [3:0]  rd_cnt_q;   // READ cycle 0..8
    logic [15:0] tmo_cnt_q;
    logic        stale_q;    // a timed-out transfer may still deliver one late edge
    logic        valid_q;

    logic        rsp_valid_q;
    logic [63:0] rsp_data_q;
    logic        rsp_timeout_q;
    logic [2:0]  mb_windex_q;
    logic [7:0]  mb_wdata_q;
    logic        mb_wstrb_q;
    logic [2:0]  mb_rindex_q;

    logic        valid_edge;
    logic [3:0]  wr_next;
    logic [7:0]  wr_byte;

    assign valid_edge = mb_valid_i & ~valid_q;
    assign wr_next    = wr_cnt_q + 4'd1;

    // Byte of the latched request for the next WRITE cycle.
    always_comb begin
        wr_byte = req_q[63:56];
        case (wr_next[3:1])
            3'd0:    wr_byte = req_q[63:56];
            3'd1:    wr_byte = req_q[55:48];
            3'd2:    wr_byte = req_q[47:40];
            3'd3:    wr_byte = req_q[39:32];
            3'd4:    wr_byte = req_q[31:24];
            3'd5:    wr_byte = req_q[23:16];
            3'd6:    wr_byte = req_q[15:8];
            default: wr_byte = req_q[7:0];
        endcase
    end

    // Outputs are registered one step ahead: every transition loads the values the
    // next cycle must present.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q       <= StIdle;
            req_q         <= '0;
            wr_cnt_q      <= '0;
            rd_cnt_q      <= '0;
            tmo_cnt_q     <= '0;
            stale_q       <= 1'b0;
            valid_q       <= 1'b0;
            rsp_valid_q   <= 1'b0;
            rsp_data_q    <= '0;
            rsp_timeout_q <= 1'b0;
            mb_windex_q   <= '0;
            mb_wdata_q    <= '0;
            mb_wstrb_q    <= 1'b0;
            mb_rindex_q   <= '0;
        end else begin
            valid_q <= mb_valid_i;

            // The late edge of an abandoned transfer arriving outside WAIT retires it.
            if (state_q != StWait && valid_edge && stale_q) begin
                stale_q <= 1'b0;
            end

            unique case (state_q)
                StIdle: begin
                    if (req_valid_i) begin
                        req_q         <= req_data_i;
                        rsp_timeout_q <= 1'b0;
                        wr_cnt_q      <= '0;
                        mb_windex_q   <= 3'd0;
                        mb_wdata_q    <= req_data_i[63:56];
                        mb_wstrb_q    <= 1'b1;
                        state_q       <= StWrite;
                    end
                end

                StWrite: begin
                    if (wr_cnt_q == 4'd15) begin
                        // Byte 7 strobe already fell; the mailbox transfer is armed.
                        tmo_cnt_q <= '0;
                        state_q   <= StWait;
                    end else begin
                        wr_cnt_q    <= wr_next;
                        mb_windex_q <= wr_next[3:1];
                        mb_wdata_q  <= wr_byte;
                        mb_wstrb_q  <= ~wr_next[0];
                    end
                end

                StWait: begin
                    tmo_cnt_q <= tmo_cnt_q + 16'd1;
                    if (valid_edge) begin
                        if (stale_q) begin
                            // Edge belongs to the previous, abandoned transfer.
                            stale_q <= 1'b0;
                        end else begin
                            rd_cnt_q    <= '0;
                            mb_rindex_q <= 3'd0;
                            state_q     <= StRead;
                        end
                    end else if (tmo_cnt_q >= TmoLast) begin
                        // >= also catches a limit cycle spent consuming a stale edge.
                        rsp_timeout_q <= 1'b1;
                        rsp_data_q    <= '0;
                        rsp_valid_q   <= 1'b1;
                        stale_q       <= 1'b1;
                        state_q       <= StResp;
                    end
                end

                StRead: begin
                    rd_cnt_q <= rd_cnt_q + 4'd1;
                    if (rd_cnt_q < 4'd7) begin
                        mb_rindex_q <= rd_cnt_q[2:0] + 3'd1;
                    end
                    // Read data lags the index by one cycle; shifting in eight bytes
                    // leaves byte 0 in [63:56].
                    if (rd_cnt_q != 4'd0) begin
                        rsp_data_q <= {rsp_data_q[55:0], mb_rdata_i};
                    end
                    if (rd_cnt_q == 4'd8) begin
                        rsp_valid_q   <= 1'b1;
                        rsp_timeout_q <= 1'b0;
                        state_q       <= StResp;
                    end
                end

                StResp: begin
                    if (rsp_ready_i) begin
                        rsp_valid_q <= 1'b0;
                        state_q     <= StIdle;
                    end
                end

                default: state_q <= StIdle;
            endcase
        end
    end

    assign req_ready_o   = (state_q == StIdle);
    assign rsp_valid_o   = rsp_valid_q;
    assign rsp_data_o    = rsp_data_q;
    assign rsp_timeout_o = rsp_timeout_q;
    assign mb_windex_o   = mb_windex_q;
    assign mb_wdata_o    = mb_wdata_q;
    assign mb_wstrb_o    = mb_wstrb_q;
    assign mb_rindex_o   = mb_rindex_q;

endmodule
